simd_lane_requester: RTL and testbench

//  Per-lane memory requester between one SIMD core and the shared 8-bit data-RAM arbiter.

---
 rtl/simd_lane_requester.sv | 138 +++++++++++++
 tb/tb_simd_lane_requester.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/simd_lane_requester.sv
// simd_lane_requester: one lane's load/store requester toward the shared 8-bit data-RAM arbiter.
// Raises rden/wren until the lane holds its grant for the RAM latency, or times out with an error.
module simd_lane_requester #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned WR_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_req_ready,
  output logic          o_resp_valid,
  output logic [DW-1:0] o_resp_rdata,
  output logic          o_resp_err,
  output logic          o_rden,
  output logic          o_wren,
  output logic [AW-1:0] o_addr_out,
  output logic [DW-1:0] o_din_out,
  input  logic          i_acq,
  input  logic [DW-1:0] i_dq_lane
);

  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned LW      = $clog2(MAX_LAT + 1);
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0] RD_TGT = LW'(RD_LAT);
  localparam logic [LW-1:0] WR_TGT = LW'(WR_LAT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_PRE = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StResp} state_e;

  state_e        r_state;
  logic          r_we;
  logic          r_rden;
  logic          r_wren;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_rdata;
  logic          r_resp_err;
  logic [CW-1:0] r_wait;
  logic [LW-1:0] r_lat;

  logic [LW-1:0] w_lat_tgt;

  assign w_lat_tgt = r_we ? WR_TGT : RD_TGT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_rden       <= 1'b0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_wait       <= '0;
      r_lat        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_addr     <= i_req_addr;
            r_din      <= i_req_wdata;
            r_rden     <= ~i_req_we;
            r_wren     <= i_req_we;
            r_resp_err <= 1'b0;
            r_wait     <= '0;
            r_lat      <= '0;
            r_state    <= StReq;
          end
        end
        StReq: begin
          if (r_wait == TO_MAX) begin
            // Timeout already committed: strobes were dropped a cycle ago.
            r_resp_valid <= 1'b1;
            r_state      <= StResp;
          end else if (i_acq) begin
            r_lat   <= LW'(1);
            r_state <= StHold;
          end else begin
            r_wait <= r_wait + CW'(1);
            if (r_wait == TO_PRE) begin
              r_rden     <= 1'b0;
              r_wren     <= 1'b0;
              r_resp_err <= 1'b1;
            end
          end
        end
        StHold: begin
          if (!i_acq) begin
            // Grant lost: retry from REQ, wait counter keeps its value.
            r_lat   <= '0;
            r_state <= StReq;
          end else if (r_lat == w_lat_tgt) begin
            if (!r_we) begin
              r_resp_rdata <= i_dq_lane;
            end
            r_resp_err   <= 1'b0;
            r_rden       <= 1'b0;
            r_wren       <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= StResp;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == StIdle);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_rden       = r_rden;
  assign o_wren       = r_wren;
  assign o_addr_out   = r_addr;
  assign o_din_out    = r_din;

endmodule

// File: tb/tb_simd_lane_requester.sv
// Directed bench for simd_lane_requester (RD_LAT=2, WR_LAT=1, TIMEOUT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_simd_lane_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       rden;
  logic       wren;
  logic [7:0] addr_out;
  logic [7:0] din_out;
  logic       acq;
  logic [7:0] dq_lane;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simd_lane_requester #(
    .AW      (8),
    .DW      (8),
    .RD_LAT  (2),
    .WR_LAT  (1),
    .TIMEOUT (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_ready  (req_ready),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_rden       (rden),
    .o_wren       (wren),
    .o_addr_out   (addr_out),
    .o_din_out    (din_out),
    .i_acq        (acq),
    .i_dq_lane    (dq_lane)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 8'hFF;
    acq = 1'b1; dq_lane = 8'hFF;
    tick; tick;
    rst = 1'b0; req_valid = 1'b0; acq = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if ({rden, wren} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got %b want 00", {rden, wren}); end
    n_cmp++; if ({resp_valid, resp_err} !== 2'b00) begin n_bad++; $display("FAIL reset_resp got %b want 00", {resp_valid, resp_err}); end
    n_cmp++; if ({addr_out, din_out, resp_rdata} !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h want 000000", {addr_out, din_out, resp_rdata}); end
    tick;
  endtask

  task automatic test_load_immediate;
    int resp_k = 0;
    int n_resp = 0;
    logic [7:0] rd = 8'h00;
    logic err = 1'bx;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL load_pre_ready got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12; req_wdata = 8'h00; acq = 1'b1; dq_lane = 8'hA5;
    tick;
    req_valid = 1'b0;
    n_cmp++; if ({rden, wren} !== 2'b10) begin n_bad++; $display("FAIL load_strobes got %b want 10", {rden, wren}); end
    n_cmp++; if (addr_out !== 8'h12) begin n_bad++; $display("FAIL load_addr got %h want 12", addr_out); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL load_busy_ready got %b want 0", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      if (resp_valid) begin n_resp++; resp_k = k; rd = resp_rdata; err = resp_err; end
      tick;
    end
    acq = 1'b0;
    n_cmp++; if (n_resp !== 1) begin n_bad++; $display("FAIL load_resp_count got %0d want 1", n_resp); end
    n_cmp++; if (resp_k !== 4) begin n_bad++; $display("FAIL load_latency got %0d want 4", resp_k); end
    n_cmp++; if ({rd, err} !== {8'hA5, 1'b0}) begin n_bad++; $display("FAIL load_rdata_err got %h/%b want a5/0", rd, err); end
  endtask

  task automatic test_store_late_grant;
    int wr_cycles = 0;
    int rd_seen = 0;
    int resp_k = 0;
    int n_resp = 0;
    logic err = 1'bx;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h34; req_wdata = 8'h5C; acq = 1'b0;
    tick;
    req_valid = 1'b0;
    n_cmp++; if ({addr_out, din_out} !== 16'h345C) begin n_bad++; $display("FAIL store_addr_din got %h want 345c", {addr_out, din_out}); end
    for (int k = 1; k <= 8; k++) begin
      if (wren) wr_cycles++;
      if (rden) rd_seen++;
      if (resp_valid) begin n_resp++; resp_k = k; err = resp_err; end
      acq = (k >= 3);
      tick;
    end
    acq = 1'b0;
    n_cmp++; if (wr_cycles !== 4) begin n_bad++; $display("FAIL store_wren_cycles got %0d want 4", wr_cycles); end
    n_cmp++; if (rd_seen !== 0) begin n_bad++; $display("FAIL store_rden_seen got %0d want 0", rd_seen); end
    n_cmp++; if (n_resp !== 1 || resp_k !== 5) begin n_bad++; $display("FAIL store_resp got %0d at %0d want 1 at 5", n_resp, resp_k); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL store_err got %b want 0", err); end
    n_cmp++; if (resp_rdata !== 8'hA5) begin n_bad++; $display("FAIL store_rdata_hold got %h want a5", resp_rdata); end
  endtask

  task automatic test_grant_lost;
    int rd_cycles = 0;
    int resp_k = 0;
    int n_resp = 0;
    logic [7:0] rd = 8'h00;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h21; acq = 1'b0; dq_lane = 8'h11;
    tick;
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (rden) rd_cycles++;
      if (resp_valid) begin n_resp++; resp_k = k; rd = resp_rdata; end
      acq = (k == 1) || (k >= 4);
      dq_lane = (k == 6) ? 8'h7E : 8'h11;
      tick;
    end
    acq = 1'b0;
    n_cmp++; if (rd_cycles !== 6) begin n_bad++; $display("FAIL lost_rden_cycles got %0d want 6", rd_cycles); end
    n_cmp++; if (n_resp !== 1 || resp_k !== 7) begin n_bad++; $display("FAIL lost_resp got %0d at %0d want 1 at 7", n_resp, resp_k); end
    n_cmp++; if (rd !== 8'h7E) begin n_bad++; $display("FAIL lost_rdata got %h want 7e", rd); end
  endtask

  task automatic test_timeout;
    int resp_k = 0;
    int n_resp = 0;
    logic err = 1'bx;
    logic rden8 = 1'bx;
    logic rden9 = 1'bx;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h09; acq = 1'b0; dq_lane = 8'hEE;
    tick;
    req_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 8) rden8 = rden;
      if (k == 9) rden9 = rden;
      if (resp_valid) begin n_resp++; resp_k = k; err = resp_err; end
      tick;
    end
    n_cmp++; if (n_resp !== 1 || resp_k !== 10) begin n_bad++; $display("FAIL timeout_resp got %0d at %0d want 1 at 10", n_resp, resp_k); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b want 1", err); end
    n_cmp++; if ({rden8, rden9} !== 2'b10) begin n_bad++; $display("FAIL timeout_rden_drop got %b want 10", {rden8, rden9}); end
    n_cmp++; if (resp_rdata !== 8'h7E) begin n_bad++; $display("FAIL timeout_rdata_hold got %h want 7e", resp_rdata); end
  endtask

  task automatic test_reset_in_hold;
    int n_resp = 0;
    int resp_k = 0;
    logic err = 1'bx;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; acq = 1'b1; dq_lane = 8'h44;
    tick;
    req_valid = 1'b0;
    tick;
    n_cmp++; if (rden !== 1'b1) begin n_bad++; $display("FAIL rsthold_pre_rden got %b want 1", rden); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if ({rden, wren, req_ready, resp_valid} !== 4'b0010) begin n_bad++; $display("FAIL rsthold_after got %b want 0010", {rden, wren, req_ready, resp_valid}); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rsthold_err got %b want 0", resp_err); end
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) n_resp++;
      tick;
    end
    n_cmp++; if (n_resp !== 0) begin n_bad++; $display("FAIL rsthold_no_resp got %0d want 0", n_resp); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h56; req_wdata = 8'h9A;
    tick;
    req_valid = 1'b0;
    n_cmp++; if ({wren, addr_out, din_out} !== {1'b1, 16'h569A}) begin n_bad++; $display("FAIL rsthold_fresh_req got %h want 1569a", {wren, addr_out, din_out}); end
    for (int k = 1; k <= 5; k++) begin
      if (resp_valid) begin n_resp++; resp_k = k; err = resp_err; end
      tick;
    end
    acq = 1'b0;
    n_cmp++; if (n_resp !== 1 || resp_k !== 3 || err !== 1'b0) begin n_bad++; $display("FAIL rsthold_fresh_resp got %0d at %0d err %b want 1 at 3 err 0", n_resp, resp_k, err); end
    n_cmp++; if (resp_rdata !== 8'h00) begin n_bad++; $display("FAIL rsthold_rdata got %h want 00", resp_rdata); end
  endtask

  task automatic test_back_to_back;
    int first_k = 0;
    int second_k = 0;
    logic [7:0] rd1 = 8'h00;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_pre_ready got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h77; acq = 1'b1; dq_lane = 8'hD2;
    tick;
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (req_ready !== ((k == 5) || (k == 10))) begin
        n_bad++; $display("FAIL b2b_ready cycle %0d got %b want %b", k, req_ready, (k == 5) || (k == 10));
      end
      n_cmp++;
      if (addr_out !== ((k <= 5) ? 8'h77 : 8'h78)) begin
        n_bad++; $display("FAIL b2b_addr cycle %0d got %h want %h", k, addr_out, (k <= 5) ? 8'h77 : 8'h78);
      end
      if (resp_valid) begin
        if (first_k == 0) begin first_k = k; rd1 = resp_rdata; end
        else if (second_k == 0) second_k = k;
      end
      if (k == 1) req_addr = 8'h78;
      tick;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick;
    acq = 1'b0;
    n_cmp++; if (first_k !== 4 || second_k !== 9) begin n_bad++; $display("FAIL b2b_resp_cycles got %0d,%0d want 4,9", first_k, second_k); end
    n_cmp++; if (rd1 !== 8'hD2) begin n_bad++; $display("FAIL b2b_rdata got %h want d2", rd1); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_drain_ready got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    acq = 1'b0; dq_lane = 8'h00;
    #1;
    test_reset;
    test_load_immediate;
    test_store_late_grant;
    test_grant_lost;
    test_timeout;
    test_reset_in_hold;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
